// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver (master) and the consumer/line side (slave).
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  Busy;

    modport master (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );

    modport slave (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, Busy
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchroniser, OVERSAMPLE clocks per bit with a 3-sample
// majority vote mid-bit, optional even/odd parity, one stop bit, one-cycle result pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.master bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int M     = OVERSAMPLE / 2;

    localparam logic [CNT_W-1:0] SMP_0    = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] SMP_1    = CNT_W'(M);
    localparam logic [CNT_W-1:0] SMP_2    = CNT_W'(M + 1);
    localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(M + 2);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    logic                  rx_meta_p0;
    logic                  rx_s;
    logic [2:0]            smp_p1;
    logic                  vote;
    logic [2:0]            state;
    logic [CNT_W-1:0]      edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  dv_q;
    logic                  perr_q;
    logic                  serr_q;

    // Stage p0: bring the asynchronous line into the CLK domain
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= bus.RX_IN;
            rx_s       <= rx_meta_p0;
        end
    end

    // Stage p1: capture the three mid-bit samples; the vote is stable from VOTE_AT
    always_ff @(posedge CLK) begin
        if (state != IDLE) begin
            if (edge_cnt == SMP_0) smp_p1[0] <= rx_s;
            if (edge_cnt == SMP_1) smp_p1[1] <= rx_s;
            if (edge_cnt == SMP_2) smp_p1[2] <= rx_s;
        end
    end

    assign vote = maj3(smp_p1);

    always_ff @(posedge CLK) begin
        if (state == DATA && edge_cnt == VOTE_AT) begin
            shreg <= {vote, shreg[DATA_WIDTH-1:1]};
        end
    end

    // Stage p2: frame sequencing and registered result pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
            par_bad   <= 1'b0;
            p_data_q  <= '0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            perr_q <= 1'b0;
            serr_q <= 1'b0;

            // The IDLE cycle that first sees the line low is sample 0 of the start bit
            if (state == IDLE) begin
                edge_cnt <= rx_s ? '0 : CNT_W'(1);
            end else if (edge_cnt == BIT_END) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state     <= START;
                        bit_cnt   <= '0;
                        par_bad   <= 1'b0;
                        par_en_l  <= bus.PAR_EN;
                        par_typ_l <= bus.PAR_TYP;
                    end
                end
                START: begin
                    if (edge_cnt == VOTE_AT && vote) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                    end else if (edge_cnt == BIT_END) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (edge_cnt == BIT_END) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (edge_cnt == VOTE_AT) par_bad <= (vote != exp_parity(shreg, par_typ_l));
                    if (edge_cnt == BIT_END) state <= STOP;
                end
                STOP: begin
                    // Leave at the vote point so a back-to-back start bit is not missed
                    if (edge_cnt == VOTE_AT) begin
                        state    <= IDLE;
                        edge_cnt <= '0;
                        dv_q     <= vote & ~par_bad;
                        perr_q   <= par_bad;
                        serr_q   <= ~vote;
                        if (vote && !par_bad) p_data_q <= shreg;
                    end
                end
                default: begin
                    state    <= IDLE;
                    edge_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = dv_q;
    assign bus.PAR_ERR    = perr_q;
    assign bus.STP_ERR    = serr_q;
    assign bus.Busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed frames checked against a waveform-level decoder model.
module tb_uart_rx;
    localparam int OS = 8;
    localparam int DW = 8;
    localparam int M  = OS / 2;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx #(.OVERSAMPLE(OS), .DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic          dv;
        logic          perr;
        logic          serr;
        logic [DW-1:0] pdata;
        int            cyc;
    } exp_t;

    exp_t          expq[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            dv_cnt = 0;
    int            perr_cnt = 0;
    int            serr_cnt = 0;
    logic          busy_seen = 1'b0;
    logic [DW-1:0] model_pdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Every result pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        exp_t e;
        if (bus.Busy) busy_seen = 1'b1;
        if (!RST && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (bus.DATA_VALID) dv_cnt++;
            if (bus.PAR_ERR) perr_cnt++;
            if (bus.STP_ERR) serr_cnt++;
            if (expq.size() == 0) begin
                check_eq("unexpected_pulse", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 3'b000);
            end else begin
                e = expq.pop_front();
                check_eq("pulse_cycle", cyc, e.cyc);
                check_eq("data_valid", bus.DATA_VALID, e.dv);
                check_eq("par_err", bus.PAR_ERR, e.perr);
                check_eq("stp_err", bus.STP_ERR, e.serr);
                check_eq("p_data", bus.P_DATA, e.pdata);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            bus.RX_IN = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic pen, input logic ptyp,
                              input logic pflip, input logic stop_v, input int gbit,
                              input int gpos, input int abort_at);
        logic          wav[$];
        logic          v[$];
        logic [DW-1:0] dec;
        logic          pbit;
        exp_t          e;
        int            nbits;
        int            ones;
        repeat (OS) wav.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (OS) wav.push_back(data[i]);
        pbit = ((($countones(data) % 2) != 0) ^ ptyp) ^ pflip;
        if (pen) repeat (OS) wav.push_back(pbit);
        repeat (OS) wav.push_back(stop_v);
        if (gbit >= 1 && gbit <= DW) wav[gbit*OS + gpos] = ~wav[gbit*OS + gpos];

        // Decode the wire as the receiver should: majority of the three middle samples
        nbits = wav.size() / OS;
        for (int b = 0; b < nbits; b++)
            v.push_back((int'(wav[b*OS+M-1]) + int'(wav[b*OS+M]) + int'(wav[b*OS+M+1])) >= 2);
        for (int i = 0; i < DW; i++) dec[i] = v[i+1];
        ones   = $countones(dec) + (pen ? int'(v[DW+1]) : 0);
        e.perr = pen && ((ones % 2) != int'(ptyp));
        e.serr = !v[nbits-1];
        e.dv   = !e.perr && !e.serr;

        for (int i = 0; i < wav.size(); i++) begin
            @(negedge CLK);
            if (i == 0) begin
                bus.PAR_EN  = pen;
                bus.PAR_TYP = ptyp;
                if (abort_at < 0) begin
                    e.cyc = cyc + 1 + 2 + (nbits - 1) * OS + M + 2;
                    if (e.dv) model_pdata = dec;
                    e.pdata = model_pdata;
                    expq.push_back(e);
                end
            end
            if (i == 3 * OS) begin
                bus.PAR_EN  = 1'($urandom_range(0, 1));
                bus.PAR_TYP = 1'($urandom_range(0, 1));
            end
            if (i == abort_at) begin
                RST = 1'b1;
                #1;
                check_eq("abort_busy", bus.Busy, 1'b0);
                check_eq("abort_pdata", bus.P_DATA, 8'h00);
                check_eq("abort_pulses", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 3'b000);
                model_pdata = '0;
                repeat (2) @(negedge CLK);
                RST        = 1'b0;
                bus.RX_IN  = 1'b1;
                return;
            end
            bus.RX_IN = wav[i];
        end
    endtask

    task automatic run_dir(input string tag, input logic [DW-1:0] data, input logic pen,
                           input logic ptyp, input logic pflip, input logic stop_v,
                           input int gbit, input logic exp_dv, input logic exp_pe,
                           input logic exp_se, input logic [DW-1:0] exp_pd);
        int d0, p0, s0;
        d0 = dv_cnt;
        p0 = perr_cnt;
        s0 = serr_cnt;
        send_frame(data, pen, ptyp, pflip, stop_v, gbit, M, -1);
        idle(2 * OS);
        check_eq({tag, "_dv_count"}, dv_cnt - d0, exp_dv);
        check_eq({tag, "_perr_count"}, perr_cnt - p0, exp_pe);
        check_eq({tag, "_serr_count"}, serr_cnt - s0, exp_se);
        check_eq({tag, "_pdata"}, bus.P_DATA, exp_pd);
    endtask

    int            t0;
    int            gap;
    logic [DW-1:0] rdata;
    logic          rpen, rptyp, rflip, rstop;
    int            rgbit;

    initial begin
        RST         = 1'b1;
        bus.RX_IN   = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        check_eq("rst_busy", bus.Busy, 1'b0);
        check_eq("rst_pdata", bus.P_DATA, 8'h00);
        check_eq("rst_pulses", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 3'b000);
        RST = 1'b0;
        idle(100);
        check_eq("idle_busy", bus.Busy, 1'b0);
        check_eq("idle_pdata", bus.P_DATA, 8'h00);
        check_eq("idle_pulses", dv_cnt + perr_cnt + serr_cnt, 0);

        run_dir("a5_nopar",   8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'hA5);
        run_dir("even_good",  8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h03);
        run_dir("even_bad",   8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h03);
        run_dir("odd_good",   8'h03, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h03);
        run_dir("odd_bad",    8'h03, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h03);
        run_dir("stop_low",   8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b1, 8'h03);
        run_dir("after_stop", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h3C);

        busy_seen = 1'b0;
        t0 = dv_cnt + perr_cnt + serr_cnt;
        repeat (2) begin
            @(negedge CLK);
            bus.RX_IN = 1'b0;
        end
        idle(3 * OS);
        check_eq("glitch_busy_seen", busy_seen, 1'b1);
        check_eq("glitch_busy_end", bus.Busy, 1'b0);
        check_eq("glitch_pulses", dv_cnt + perr_cnt + serr_cnt - t0, 0);

        run_dir("data_glitch", 8'hC6, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 8'hC6);

        t0 = dv_cnt;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
        send_frame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, -1);
        idle(2 * OS);
        check_eq("b2b_dv_count", dv_cnt - t0, 2);
        check_eq("b2b_pdata", bus.P_DATA, 8'hEE);

        send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, 3 * OS + 2);
        idle(OS);
        run_dir("post_reset", 8'h88, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1, 1'b0, 1'b0, 8'h88);

        for (int k = 0; k < 40; k++) begin
            rdata = DW'($urandom);
            rpen  = 1'($urandom_range(0, 1));
            rptyp = 1'($urandom_range(0, 1));
            rflip = ($urandom_range(0, 4) == 0);
            rstop = ($urandom_range(0, 4) != 0);
            rgbit = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW)) : -1;
            send_frame(rdata, rpen, rptyp, rflip, rstop, rgbit, int'($urandom_range(0, OS - 1)), -1);
            gap = rstop ? int'($urandom_range(0, 2 * OS)) : 2 * OS + int'($urandom_range(0, OS));
            idle(gap);
        end
        idle(4 * OS);
        check_eq("queue_drained", expq.size(), 0);
        check_eq("final_busy", bus.Busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
